ifmap_tile_sequencer: RTL and testbench
=======================================

// Module: ifmap_tile_sequencer
// PURPOSE
//  Sequences the ping-pong ifmap buffer through a run of conv tiles:
//  DMA load -> bank swap (conv_en) -> tensor-address stream -> compute done -> readback drain.
//  Drives the buffer's conv_en, w_done, n_tensor_size, tensor_addr and t_addr_vld.
//  Observes DMA w_last/r_last and the compute engine's done.
//  Sits between the AXI-Lite control regs and the ifmap buffer / compute array.
// PARAMETERS
//  ADDR_W   12  width of tensor_addr (buffer depth 2**ADDR_W)
//  TSIZE_W  16  width of tensor_size / n_tensor_size
//  TILE_W   16  width of num_tiles and the tile counter
// PORTS
//  clk            in   1        system clock
//  rstn           in   1        async active-low reset
//  enable         in   1        global enable; low = freeze all state, suppress pulses
//  start          in   1        pulse: begin a run (ignored unless IDLE)
//  num_tiles      in   TILE_W   tiles in the run; sampled on accepted start
//  tensor_size    in   TSIZE_W  words per tile; sampled on accepted start
//  dma_w_last     in   1        last beat of DMA write into buffer
//  dma_r_last     in   1        buffer r_last (readback complete)
//  addr_stall     in   1        compute back-pressure; holds the address stream
//  cmp_done       in   1        pulse: compute finished writing results for tile
//  conv_en        out  1        1-cycle pulse, swaps buffer banks
//  w_done         out  1        1-cycle pulse, opens buffer readback
//  n_tensor_size  out  TSIZE_W  registered tensor_size to buffer
//  tensor_addr    out  ADDR_W   read address to buffer
//  t_addr_vld     out  1        tensor_addr valid
//  cmp_start      out  1        1-cycle pulse to compute at RUN entry
//  busy           out  1        high in any state but IDLE
//  run_done       out  1        1-cycle pulse at end of run
//  cfg_err        out  1        sticky; start with tensor_size==0 or >2**ADDR_W
//  tile_idx       out  TILE_W   index of current tile
// BEHAVIOUR
//  Reset: FSM=IDLE.
//  Reset values: all outputs 0, including n_tensor_size, tensor_addr, tile_idx and cfg_err.
//  FSM (one-hot): IDLE, LOAD, SWAP, RUN, WAIT_CMP, DRAIN, FIN.
//  IDLE->LOAD on start when config valid: latch size, count; clear tile_idx.
//   Bad config sets cfg_err and stays in IDLE.
//   cfg_err clears only on the next valid start.
//  num_tiles==0: IDLE->FIN directly; run_done pulses 1 cycle later.
//  LOAD: wait dma_w_last, then ->SWAP.
//  SWAP: conv_en=1 for exactly 1 cycle; ->RUN; cmp_start pulses on the same edge.
//  RUN: t_addr_vld=1; tensor_addr advances 0..size-1, +1 per cycle when !addr_stall.
//   Address holds when stalled.
//   ->WAIT_CMP after the beat with addr==size-1 && !addr_stall.
//  WAIT_CMP: t_addr_vld=0; on cmp_done pulse w_done for 1 cycle, then ->DRAIN.
//   A cmp_done arriving during RUN is latched and honoured on WAIT_CMP entry.
//  DRAIN: wait dma_r_last; tile_idx++.
//   If tile_idx+1==num_tiles ->FIN, else ->LOAD.
//   dma_w_last during DRAIN is latched, so the next LOAD exits immediately
//   (overlapped prefetch allowed).
//  FIN: run_done=1 for 1 cycle; ->IDLE.
//  enable low: state, counters and latches hold; pulse outputs forced 0.
//   The pending pulse fires on the first enabled cycle.
//  start while busy: ignored, no error.
//  Mid-operation reset: immediate return to IDLE, no pulses emitted.
//  Counter widths: tensor_addr compare uses size-1 at TSIZE_W bits; no wrap beyond size-1.
// CONFIGURATION
//  SEQ_PERF_CNT_EN defined:
//   - adds output perf_cycles[31:0]: cycles busy in last run (saturating);
//   - adds output perf_stall[31:0]: RUN cycles with addr_stall (saturating);
//   - both clear on an accepted start and hold after FIN.
//  Undefined: ports absent, no counters.
// STRUCTURE
//  Shared package/header gets:
//   - state encodings (one-hot localparams);
//   - ADDR_W / TSIZE_W / TILE_W defaults.
//  One sub-module: seq_addr_gen (RUN address counter with stall and last-beat flag).
//  FSM and handshake latches stay in the top module.
// TESTING
//  1 tile, size=4, no stall, cmp_done 3 cycles after RUN exit:
//   -> addr 0,1,2,3 on consecutive cycles; 1 conv_en; 1 w_done; run_done after r_last.
//  size=8, addr_stall high on cycles 2-4 of RUN:
//   -> addr holds at 2 for 3 cycles; 8 valid beats total.
//  num_tiles=3: tile_idx goes 0,1,2; exactly 3 conv_en pulses; 1 run_done.
//   w_last during DRAIN of tile 0 -> SWAP immediately after r_last.
//  start with tensor_size=0 -> cfg_err=1, busy=0.
//   Then valid start -> cfg_err=0, run proceeds.
//  enable low across SWAP: conv_en suppressed, fires first cycle enable=1.
//   rstn low in RUN: all outputs 0 next cycle.
//  SEQ_PERF_CNT_EN build, the size=8 stall case: perf_stall==3.

Source files
------------

// File: rtl/ifmap_tile_sequencer_pkg.sv
// Shared defaults and one-hot state encoding for the ifmap tile sequencer.
package ifmap_tile_sequencer_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int TSIZE_W_DEF = 16;
  localparam int TILE_W_DEF  = 16;

  localparam int ST_IDLE     = 0;
  localparam int ST_LOAD     = 1;
  localparam int ST_SWAP     = 2;
  localparam int ST_RUN      = 3;
  localparam int ST_WAIT_CMP = 4;
  localparam int ST_DRAIN    = 5;
  localparam int ST_FIN      = 6;

  typedef enum logic [6:0] {
    S_IDLE     = 7'b1 << ST_IDLE,
    S_LOAD     = 7'b1 << ST_LOAD,
    S_SWAP     = 7'b1 << ST_SWAP,
    S_RUN      = 7'b1 << ST_RUN,
    S_WAIT_CMP = 7'b1 << ST_WAIT_CMP,
    S_DRAIN    = 7'b1 << ST_DRAIN,
    S_FIN      = 7'b1 << ST_FIN
  } state_e;

endpackage

// File: rtl/ifmap_tile_sequencer_addr_gen.sv
// seq_addr_gen: RUN-phase tensor address counter, 0..size-1, held under stall.
module seq_addr_gen
  import ifmap_tile_sequencer_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TSIZE_W = TSIZE_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               run,
  input  logic               stall,
  input  logic [TSIZE_W-1:0] size,
  output logic [ADDR_W-1:0]  addr,
  output logic               last_beat
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Compare at TSIZE_W so a full-depth tile (size == 2**ADDR_W) ends on the top address.
  always_comb begin
    last_beat = run && !stall && (TSIZE_W'(addr_q) == (size - TSIZE_W'(1)));
    addr_d    = addr_q;
    if (run && !stall)
      addr_d = last_beat ? '0 : addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign addr = addr_q;

endmodule

// File: rtl/ifmap_tile_sequencer.sv
// Ping-pong ifmap buffer tile sequencer: LOAD -> SWAP -> RUN -> WAIT_CMP -> DRAIN per tile.
// Optional SEQ_PERF_CNT_EN adds busy-cycle and RUN-stall counters.
module ifmap_tile_sequencer
  import ifmap_tile_sequencer_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TSIZE_W = TSIZE_W_DEF,
  parameter int TILE_W  = TILE_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               start,
  input  logic [TILE_W-1:0]  num_tiles,
  input  logic [TSIZE_W-1:0] tensor_size,
  input  logic               dma_w_last,
  input  logic               dma_r_last,
  input  logic               addr_stall,
  input  logic               cmp_done,
  output logic               conv_en,
  output logic               w_done,
  output logic [TSIZE_W-1:0] n_tensor_size,
  output logic [ADDR_W-1:0]  tensor_addr,
  output logic               t_addr_vld,
  output logic               cmp_start,
  output logic               busy,
  output logic               run_done,
  output logic               cfg_err,
  output logic [TILE_W-1:0]  tile_idx
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_stall
`endif
);

  localparam logic [TSIZE_W:0] MAX_SIZE = (TSIZE_W+1)'(2**ADDR_W);

  state_e             state_q, state_d;
  logic [TSIZE_W-1:0] size_q, size_d;
  logic [TILE_W-1:0]  tiles_q, tiles_d;
  logic [TILE_W-1:0]  tile_idx_q, tile_idx_d;
  logic               cfg_err_q, cfg_err_d;
  logic               wl_q, wl_d;
  logic               cd_q, cd_d;
  logic               cfg_ok, start_ok, run_act, last_beat;

  assign cfg_ok   = (tensor_size != '0) && ({1'b0, tensor_size} <= MAX_SIZE);
  assign start_ok = enable && (state_q == S_IDLE) && start && cfg_ok;
  // A beat is only offered while enabled, so a frozen cycle never looks like a consumed address.
  assign run_act  = enable && (state_q == S_RUN);

  seq_addr_gen #(.ADDR_W(ADDR_W), .TSIZE_W(TSIZE_W)) u_addr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .run       (run_act),
    .stall     (addr_stall),
    .size      (size_q),
    .addr      (tensor_addr),
    .last_beat (last_beat)
  );

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    tiles_d    = tiles_q;
    tile_idx_d = tile_idx_q;
    cfg_err_d  = cfg_err_q;
    wl_d       = wl_q;
    cd_d       = cd_q;
    conv_en    = 1'b0;
    cmp_start  = 1'b0;
    w_done     = 1'b0;
    run_done   = 1'b0;
    if (enable) begin
      unique case (state_q)
        S_IDLE: if (start) begin
          if (cfg_ok) begin
            cfg_err_d  = 1'b0;
            size_d     = tensor_size;
            tiles_d    = num_tiles;
            tile_idx_d = '0;
            wl_d       = 1'b0;
            cd_d       = 1'b0;
            state_d    = (num_tiles == '0) ? S_FIN : S_LOAD;
          end else begin
            cfg_err_d  = 1'b1;
          end
        end
        S_LOAD: if (dma_w_last || wl_q) begin
          wl_d    = 1'b0;
          state_d = S_SWAP;
        end
        S_SWAP: begin
          conv_en   = 1'b1;
          cmp_start = 1'b1;
          cd_d      = 1'b0;
          state_d   = S_RUN;
        end
        S_RUN: begin
          if (cmp_done) cd_d = 1'b1;
          if (last_beat) state_d = S_WAIT_CMP;
        end
        S_WAIT_CMP: if (cmp_done || cd_q) begin
          w_done  = 1'b1;
          cd_d    = 1'b0;
          state_d = S_DRAIN;
        end
        S_DRAIN: begin
          // Next tile's DMA may finish early; remember it so LOAD falls straight through.
          if (dma_w_last) wl_d = 1'b1;
          if (dma_r_last) begin
            tile_idx_d = tile_idx_q + TILE_W'(1);
            state_d    = ((tile_idx_q + TILE_W'(1)) == tiles_q) ? S_FIN : S_LOAD;
          end
        end
        S_FIN: begin
          run_done = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      tiles_q    <= '0;
      tile_idx_q <= '0;
      cfg_err_q  <= 1'b0;
      wl_q       <= 1'b0;
      cd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      tiles_q    <= tiles_d;
      tile_idx_q <= tile_idx_d;
      cfg_err_q  <= cfg_err_d;
      wl_q       <= wl_d;
      cd_q       <= cd_d;
    end
  end

  assign n_tensor_size = size_q;
  assign t_addr_vld    = run_act;
  assign busy          = (state_q != S_IDLE);
  assign cfg_err       = cfg_err_q;
  assign tile_idx      = tile_idx_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (start_ok) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else if (enable && busy) begin
      if (perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 32'd1;
      if (state_q == S_RUN && addr_stall && perf_stall_q != '1)
        perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_ifmap_tile_sequencer.sv
// Directed bench for ifmap_tile_sequencer: single/multi tile, stall, cfg errors, enable freeze, reset.
module tb_ifmap_tile_sequencer;

  localparam int ADDR_W  = 12;
  localparam int TSIZE_W = 16;
  localparam int TILE_W  = 16;

  logic               clk = 1'b0;
  logic               rstn;
  logic               enable, start, dma_w_last, dma_r_last, addr_stall, cmp_done;
  logic [TILE_W-1:0]  num_tiles;
  logic [TSIZE_W-1:0] tensor_size;
  logic               conv_en, w_done, t_addr_vld, cmp_start, busy, run_done, cfg_err;
  logic [TSIZE_W-1:0] n_tensor_size;
  logic [ADDR_W-1:0]  tensor_addr;
  logic [TILE_W-1:0]  tile_idx;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]        perf_cycles, perf_stall;
`endif

  ifmap_tile_sequencer #(.ADDR_W(ADDR_W), .TSIZE_W(TSIZE_W), .TILE_W(TILE_W)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .start(start),
    .num_tiles(num_tiles), .tensor_size(tensor_size),
    .dma_w_last(dma_w_last), .dma_r_last(dma_r_last),
    .addr_stall(addr_stall), .cmp_done(cmp_done),
    .conv_en(conv_en), .w_done(w_done), .n_tensor_size(n_tensor_size),
    .tensor_addr(tensor_addr), .t_addr_vld(t_addr_vld), .cmp_start(cmp_start),
    .busy(busy), .run_done(run_done), .cfg_err(cfg_err), .tile_idx(tile_idx)
`ifdef SEQ_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int conv_cnt = 0, wd_cnt = 0, rd_cnt = 0, vld_cnt = 0, stall2_cnt = 0;
  int beat_q[$];
  int tidx_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor on the falling edge, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (conv_en) begin
      conv_cnt++;
      tidx_q.push_back(int'(tile_idx));
    end
    if (w_done)   wd_cnt++;
    if (run_done) rd_cnt++;
    if (t_addr_vld) begin
      vld_cnt++;
      if (!addr_stall)            beat_q.push_back(int'(tensor_addr));
      else if (tensor_addr == 2)  stall2_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = conv_en high, 1 = t_addr_vld low
  task automatic wait_for(input int which, input string tag);
    logic hit;
    hit = 1'b0;
    for (int n = 0; n < 50; n++) begin
      #1;
      hit = (which == 0) ? conv_en : !t_addr_vld;
      if (hit) break;
      tick();
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic start_run(input int tiles, input int size);
    num_tiles   = TILE_W'(tiles);
    tensor_size = TSIZE_W'(size);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_tile(input int cmp_dly, input bit skip_w, input bit w_in_drain);
    if (!skip_w) begin
      dma_w_last = 1'b1; tick(); dma_w_last = 1'b0;
    end
    wait_for(0, "wait_swap");
    chk("cmp_start_with_swap", 32'(cmp_start), 32'd1);
    tick();
    wait_for(1, "wait_run_end");
    repeat (cmp_dly) tick();
    cmp_done = 1'b1;
    #1 chk("w_done_on_cmp", 32'(w_done), 32'd1);
    tick();
    cmp_done = 1'b0;
    if (w_in_drain) begin
      dma_w_last = 1'b1; tick(); dma_w_last = 1'b0;
    end
    dma_r_last = 1'b1; tick(); dma_r_last = 1'b0;
  endtask

  int c0, w0, r0;

  initial begin
    rstn = 1'b0; enable = 1'b1; start = 1'b0; dma_w_last = 1'b0; dma_r_last = 1'b0;
    addr_stall = 1'b0; cmp_done = 1'b0; num_tiles = '0; tensor_size = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_conv_en", 32'(conv_en), 0);
    chk("rst_addr", 32'(tensor_addr), 0);
    chk("rst_nsize", 32'(n_tensor_size), 0);
    chk("rst_tile_idx", 32'(tile_idx), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_vld", 32'(t_addr_vld), 0);
    rstn = 1'b1;
    tick();

    // 1 tile, size 4, no stall, cmp_done 3 cycles after RUN exit
    c0 = conv_cnt; w0 = wd_cnt; r0 = rd_cnt; vld_cnt = 0; beat_q.delete();
    start_run(1, 4);
    #1 chk("t1_busy", 32'(busy), 1);
    chk("t1_nsize", 32'(n_tensor_size), 4);
    do_tile(3, 1'b0, 1'b0);
    #1 chk("t1_run_done", 32'(run_done), 1);
    tick();
    chk("t1_idle", 32'(busy), 0);
    chk("t1_beats", 32'(beat_q.size()), 4);
    for (int i = 0; i < beat_q.size() && i < 4; i++) chk("t1_addr", 32'(beat_q[i]), 32'(i));
    chk("t1_vld_cycles", 32'(vld_cnt), 4);
    chk("t1_conv_cnt", 32'(conv_cnt - c0), 1);
    chk("t1_wdone_cnt", 32'(wd_cnt - w0), 1);
    chk("t1_rdone_cnt", 32'(rd_cnt - r0), 1);

    // size 8, stall on RUN cycles 2-4, cmp_done arrives during RUN
    vld_cnt = 0; stall2_cnt = 0; beat_q.delete();
    start_run(1, 8);
    dma_w_last = 1'b1; tick(); dma_w_last = 1'b0;
    wait_for(0, "t2_wait_swap");
    tick(); tick(); tick();
    addr_stall = 1'b1;
    tick(); tick(); tick();
    addr_stall = 1'b0;
    cmp_done = 1'b1;
    tick();
    cmp_done = 1'b0;
    wait_for(1, "t2_wait_run_end");
    chk("t2_w_done_latched", 32'(w_done), 1);
    tick();
    dma_r_last = 1'b1; tick(); dma_r_last = 1'b0;
    #1 chk("t2_run_done", 32'(run_done), 1);
    tick();
    chk("t2_beats", 32'(beat_q.size()), 8);
    for (int i = 0; i < beat_q.size() && i < 8; i++) chk("t2_addr", 32'(beat_q[i]), 32'(i));
    chk("t2_hold_at_2", 32'(stall2_cnt), 3);
    chk("t2_vld_cycles", 32'(vld_cnt), 11);
`ifdef SEQ_PERF_CNT_EN
    chk("t2_perf_stall", perf_stall, 3);
`endif

    // 3 tiles, size 2, w_last prefetched during tile 0 DRAIN
    c0 = conv_cnt; r0 = rd_cnt; tidx_q.delete();
    start_run(3, 2);
    do_tile(0, 1'b0, 1'b1);
    #1 chk("t3_load_no_conv", 32'(conv_en), 0);
    chk("t3_tile_idx1", 32'(tile_idx), 1);
    tick();
    chk("t3_prefetch_swap", 32'(conv_en), 1);
    do_tile(0, 1'b1, 1'b0);
    do_tile(0, 1'b0, 1'b0);
    #1 chk("t3_run_done", 32'(run_done), 1);
    tick();
    chk("t3_conv_cnt", 32'(conv_cnt - c0), 3);
    chk("t3_rdone_cnt", 32'(rd_cnt - r0), 1);
    chk("t3_tidx_n", 32'(tidx_q.size()), 3);
    for (int i = 0; i < tidx_q.size() && i < 3; i++) chk("t3_tidx", 32'(tidx_q[i]), 32'(i));

    // config errors, then valid starts
    start_run(1, 0);
    #1 chk("t4_err_zero", 32'(cfg_err), 1);
    chk("t4_err_busy", 32'(busy), 0);
    start_run(1, 4097);
    #1 chk("t4_err_big", 32'(cfg_err), 1);
    chk("t4_err_big_busy", 32'(busy), 0);
    start_run(0, 4);
    #1 chk("t4_err_clr", 32'(cfg_err), 0);
    chk("t4_zero_tiles_fin", 32'(run_done), 1);
    tick();
    chk("t4_zero_tiles_idle", 32'(busy), 0);

    // full-depth tile accepted; enable low across SWAP; reset during RUN
    c0 = conv_cnt;
    start_run(1, 4096);
    #1 chk("t5_nsize_max", 32'(n_tensor_size), 4096);
    chk("t5_cfg_ok", 32'(cfg_err), 0);
    dma_w_last = 1'b1; tick(); dma_w_last = 1'b0;
    enable = 1'b0;
    #1 chk("t5_conv_supp", 32'(conv_en), 0);
    tick(); tick();
    chk("t5_conv_supp2", 32'(conv_en), 0);
    chk("t5_busy_frozen", 32'(busy), 1);
    enable = 1'b1;
    #1 chk("t5_conv_fire", 32'(conv_en), 1);
    tick(); tick(); tick();
    chk("t5_addr2", 32'(tensor_addr), 2);
    chk("t5_vld", 32'(t_addr_vld), 1);
    chk("t5_conv_once", 32'(conv_cnt - c0), 1);
    rstn = 1'b0;
    #1 chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_vld", 32'(t_addr_vld), 0);
    chk("t5_rst_addr", 32'(tensor_addr), 0);
    chk("t5_rst_nsize", 32'(n_tensor_size), 0);
    tick();
    chk("t5_rst_hold_busy", 32'(busy), 0);
    chk("t5_rst_tile_idx", 32'(tile_idx), 0);
    rstn = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
